data_mem_pipe: RTL and testbench

//   Parametrised single-port data memory for the CPU pipeline MEM stage.

---
 rtl/data_mem_if.sv | 27 ++
 rtl/data_mem_pipe.sv | 155 +++++++++++++++
 tb/tb_data_mem_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Request/response bus between the MEM stage and the data memory.
interface data_mem_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              read;
  logic              write;
  logic              ready;
  logic [DATA_W-1:0] readout;
  logic              rvalid;
  logic              err;

  modport master (
    output addr, wdata, be, read, write,
    input  ready, readout, rvalid, err
  );

  modport slave (
    input  addr, wdata, be, read, write,
    output ready, readout, rvalid, err
  );
endinterface

// File: rtl/data_mem_pipe.sv
// Single-port data memory with byte enables, post-reset clear sequence,
// configurable read latency (1 or 2), read-valid strobe and error strobe.
module data_mem_pipe #(
  parameter int unsigned      DATA_W   = 16,
  parameter int unsigned      ADDR_W   = 16,
  parameter int unsigned      DEPTH    = 256,
  parameter int unsigned      RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic        clk,
  input  logic        reset,
  data_mem_if.slave   bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AW1   = ADDR_W + 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  clr_ptr;
  logic              ready_q;
  logic              rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] readout_q;

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wval;
  logic [BE_W-1:0]   lane_we;
  logic              imm_err;
  logic              head_vld;
  logic              head_err;
  logic [DATA_W-1:0] head_data;
  logic              feed_vld;
  logic              feed_err;
  logic [DATA_W-1:0] feed_data;

  // Widened compare so DEPTH == 2**ADDR_W does not wrap to zero.
  assign in_range = ({1'b0, bus.addr} < AW1'(DEPTH));
  assign idx      = bus.addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the write-port, immediate-error and read-issue controls.
  always_comb begin
    next_state = state;
    waddr      = clr_ptr;
    wval       = INIT_VAL;
    lane_we    = '0;
    imm_err    = 1'b0;
    head_vld   = 1'b0;
    head_err   = 1'b0;
    head_data  = '0;
    case (state)
      ST_INIT: begin
        lane_we = '1;
        if (clr_ptr == IDX_W'(DEPTH - 1)) begin
          next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        waddr = idx;
        wval  = bus.wdata;
        if (bus.write) begin
          if (in_range) begin
            lane_we = bus.be;
          end else begin
            imm_err = 1'b1;
          end
          if (bus.read) begin
            imm_err = 1'b1;
          end
        end else if (bus.read) begin
          head_vld  = 1'b1;
          head_err  = !in_range;
          head_data = in_range ? mem[idx] : '0;
        end
      end
      default: next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(BE_W); i++) begin
      if (lane_we[i]) begin
        mem[waddr][8*i +: 8] <= wval[8*i +: 8];
      end
    end
  end

  // Optional extra stage so read data, rvalid and read errors share latency.
  if (RD_LAT >= 2) begin : g_lat2
    logic              s1_vld;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk) begin
      if (!reset) begin
        s1_vld  <= 1'b0;
        s1_err  <= 1'b0;
        s1_data <= '0;
      end else begin
        s1_vld  <= head_vld;
        s1_err  <= head_err;
        s1_data <= head_data;
      end
    end

    assign feed_vld  = s1_vld;
    assign feed_err  = s1_err;
    assign feed_data = s1_data;
  end else begin : g_lat1
    assign feed_vld  = head_vld;
    assign feed_err  = head_err;
    assign feed_data = head_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_ptr   <= '0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      readout_q <= '0;
    end else begin
      if (state == ST_INIT) begin
        clr_ptr <= clr_ptr + IDX_W'(1);
      end
      ready_q  <= (next_state == ST_IDLE);
      rvalid_q <= feed_vld;
      err_q    <= feed_err | imm_err;
      if (feed_vld) begin
        readout_q <= feed_data;
      end
    end
  end

  assign bus.ready   = ready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.err     = err_q;
  assign bus.readout = readout_q;
endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench: dut1 uses the default read latency of 1, dut2 uses RD_LAT=2.
module tb_data_mem_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset1;
  logic reset2;
  int   checks = 0;
  int   errors = 0;

  data_mem_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
  data_mem_if #(.DATA_W(16), .ADDR_W(16)) bus2 ();

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(1),
                  .INIT_VAL(16'h0000)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));
  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(2),
                  .INIT_VAL(16'h0000)) dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  task automatic rd1(input logic [15:0] a, output logic [15:0] d,
                     output logic v, output logic e);
    bus1.addr = a;
    bus1.read = 1'b1;
    @(negedge clk);
    d = bus1.readout;
    v = bus1.rvalid;
    e = bus1.err;
    bus1.read = 1'b0;
  endtask

  task automatic wr1(input logic [15:0] a, input logic [15:0] wd,
                     input logic [1:0] b, output logic e);
    bus1.addr  = a;
    bus1.wdata = wd;
    bus1.be    = b;
    bus1.write = 1'b1;
    @(negedge clk);
    e = bus1.err;
    bus1.write = 1'b0;
  endtask

  task automatic wr2(input logic [15:0] a, input logic [15:0] wd);
    bus2.addr  = a;
    bus2.wdata = wd;
    bus2.be    = 2'b11;
    bus2.write = 1'b1;
    @(negedge clk);
    bus2.write = 1'b0;
  endtask

  task automatic test_reset;
    logic bad;
    reset1 = 1'b0;
    reset2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus1.ready !== 1'b0 || bus1.rvalid !== 1'b0 || bus1.err !== 1'b0 ||
        bus1.readout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rvalid=%b err=%b readout=%h expected 0/0/0/0000",
               bus1.ready, bus1.rvalid, bus1.err, bus1.readout);
    end
    reset1 = 1'b1;
    reset2 = 1'b1;
    // A write held through INIT must be ignored.
    bus1.addr  = 16'd3;
    bus1.wdata = 16'hBEEF;
    bus1.be    = 2'b11;
    bus1.write = 1'b1;
    bad = 1'b0;
    repeat (255) begin
      @(negedge clk);
      if (bus1.err !== 1'b0 || bus1.rvalid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL init_ignores_req saw err or rvalid during INIT expected none");
    end
    checks++;
    if (bus1.ready !== 1'b0 || bus2.ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_255 ready1=%b ready2=%b expected 0/0", bus1.ready, bus2.ready);
    end
    @(negedge clk);
    bus1.write = 1'b0;
    checks++;
    if (bus1.ready !== 1'b1 || bus2.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_256 ready1=%b ready2=%b expected 1/1", bus1.ready, bus2.ready);
    end
  endtask

  task automatic test_init_reads;
    logic [15:0] addrs [4] = '{16'd0, 16'd1, 16'd255, 16'd3};
    logic [15:0] d;
    logic v, e;
    for (int i = 0; i < 4; i++) begin
      rd1(addrs[i], d, v, e);
      checks++;
      if (d !== 16'h0000 || v !== 1'b1 || e !== 1'b0) begin
        errors++;
        $display("FAIL init_read addr=%0d readout=%h rvalid=%b err=%b expected 0000/1/0",
                 addrs[i], d, v, e);
      end
    end
    @(negedge clk);
    checks++;
    if (bus1.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_strobe rvalid=%b expected 0", bus1.rvalid);
    end
  endtask

  task automatic test_write_read;
    logic [15:0] d;
    logic v, e;
    wr1(16'd1, 16'h0005, 2'b11, e);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL write_err err=%b expected 0", e);
    end
    rd1(16'd1, d, v, e);
    checks++;
    if (d !== 16'h0005 || v !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL write_read readout=%h rvalid=%b err=%b expected 0005/1/0", d, v, e);
    end
    @(negedge clk);
    checks++;
    if (bus1.rvalid !== 1'b0 || bus1.readout !== 16'h0005) begin
      errors++;
      $display("FAIL readout_hold rvalid=%b readout=%h expected 0/0005",
               bus1.rvalid, bus1.readout);
    end
  endtask

  task automatic test_byte_enable;
    logic [15:0] d;
    logic v, e;
    wr1(16'd50, 16'hABCD, 2'b11, e);
    wr1(16'd50, 16'h1234, 2'b01, e);
    wr1(16'd50, 16'hFFFF, 2'b00, e);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL be_zero_err err=%b expected 0", e);
    end
    rd1(16'd50, d, v, e);
    checks++;
    if (d !== 16'hAB34 || v !== 1'b1) begin
      errors++;
      $display("FAIL byte_enable readout=%h rvalid=%b expected AB34/1", d, v);
    end
  endtask

  task automatic test_out_of_range;
    logic [15:0] d;
    logic v, e;
    rd1(16'd300, d, v, e);
    checks++;
    if (d !== 16'h0000 || v !== 1'b1 || e !== 1'b1) begin
      errors++;
      $display("FAIL oor_read readout=%h rvalid=%b err=%b expected 0000/1/1", d, v, e);
    end
    wr1(16'd300, 16'hFFFF, 2'b11, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL oor_write err=%b expected 1", e);
    end
    rd1(16'd44, d, v, e);
    checks++;
    if (d !== 16'h0000 || v !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL no_alias readout=%h rvalid=%b err=%b expected 0000/1/0", d, v, e);
    end
  endtask

  task automatic test_conflict;
    logic [15:0] d;
    logic v, e;
    bus1.addr  = 16'd2;
    bus1.wdata = 16'h0007;
    bus1.be    = 2'b11;
    bus1.read  = 1'b1;
    bus1.write = 1'b1;
    @(negedge clk);
    bus1.read  = 1'b0;
    bus1.write = 1'b0;
    checks++;
    if (bus1.err !== 1'b1 || bus1.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL conflict err=%b rvalid=%b expected 1/0", bus1.err, bus1.rvalid);
    end
    rd1(16'd2, d, v, e);
    checks++;
    if (d !== 16'h0007 || v !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL conflict_write readout=%h rvalid=%b err=%b expected 0007/1/0", d, v, e);
    end
  endtask

  task automatic test_back_to_back;
    logic        ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] ed [5] = '{16'h0000, 16'h0011, 16'h0022, 16'h0033, 16'h0033};
    wr2(16'd1, 16'h0011);
    wr2(16'd2, 16'h0022);
    wr2(16'd3, 16'h0033);
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        bus2.addr = 16'(c + 1);
        bus2.read = 1'b1;
      end else begin
        bus2.read = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus2.rvalid !== ev[c] || (c > 0 && bus2.readout !== ed[c])) begin
        errors++;
        $display("FAIL lat2_b2b cycle=%0d rvalid=%b readout=%h expected %b/%h",
                 c, bus2.rvalid, bus2.readout, ev[c], ed[c]);
      end
    end
  endtask

  task automatic test_err_merge;
    bus2.addr = 16'd300;
    bus2.read = 1'b1;
    @(negedge clk);
    checks++;
    if (bus2.err !== 1'b0) begin
      errors++;
      $display("FAIL merge_early err=%b expected 0", bus2.err);
    end
    bus2.read  = 1'b0;
    bus2.wdata = 16'hFFFF;
    bus2.be    = 2'b11;
    bus2.write = 1'b1;
    @(negedge clk);
    bus2.write = 1'b0;
    checks++;
    if (bus2.err !== 1'b1 || bus2.rvalid !== 1'b1 || bus2.readout !== 16'h0000) begin
      errors++;
      $display("FAIL merge_pulse err=%b rvalid=%b readout=%h expected 1/1/0000",
               bus2.err, bus2.rvalid, bus2.readout);
    end
    @(negedge clk);
    checks++;
    if (bus2.err !== 1'b0) begin
      errors++;
      $display("FAIL merge_single err=%b expected 0", bus2.err);
    end
  endtask

  task automatic test_reset_mid_read;
    bus2.addr = 16'd1;
    bus2.read = 1'b1;
    @(negedge clk);
    reset2 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus2.rvalid !== 1'b0 || bus2.ready !== 1'b0 || bus2.readout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_read rvalid=%b ready=%b readout=%h expected 0/0/0000",
               bus2.rvalid, bus2.ready, bus2.readout);
    end
    reset2    = 1'b1;
    bus2.read = 1'b0;
    @(negedge clk);
    checks++;
    if (bus2.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL pipe_flush rvalid=%b expected 0", bus2.rvalid);
    end
  endtask

  task automatic test_reset_mid_init;
    repeat (99) @(negedge clk);
    reset2 = 1'b0;
    @(negedge clk);
    reset2 = 1'b1;
    repeat (255) @(negedge clk);
    checks++;
    if (bus2.ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_255 ready=%b expected 0", bus2.ready);
    end
    @(negedge clk);
    checks++;
    if (bus2.ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_256 ready=%b expected 1", bus2.ready);
    end
    bus2.addr = 16'd1;
    bus2.read = 1'b1;
    @(negedge clk);
    bus2.read = 1'b0;
    @(negedge clk);
    checks++;
    if (bus2.rvalid !== 1'b1 || bus2.readout !== 16'h0000) begin
      errors++;
      $display("FAIL recleared rvalid=%b readout=%h expected 1/0000",
               bus2.rvalid, bus2.readout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset1 = 1'b0;
    reset2 = 1'b0;
    bus1.addr = '0; bus1.wdata = '0; bus1.be = '0; bus1.read = 1'b0; bus1.write = 1'b0;
    bus2.addr = '0; bus2.wdata = '0; bus2.be = '0; bus2.read = 1'b0; bus2.write = 1'b0;
    @(negedge clk);
    test_reset();
    test_init_reads();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_conflict();
    test_back_to_back();
    test_err_merge();
    test_reset_mid_read();
    test_reset_mid_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
